// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch control path.
//   fetch_state_t : sequencer state encoding
//   PCSRC_*       : select codes for the PC input mux (shared with the PC)
//   redirectSrc() : PC mux code for a redirect; a jalr target wins over a branch
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_HALTED
  } fetch_state_t;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_ALU    = 2'b10;

  // JumpReg outranks BranchTaken when both request a redirect.
  function automatic logic [1:0] redirectSrc(input logic jumpReg);
    return jumpReg ? PCSRC_ALU : PCSRC_TARGET;
  endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// ---------------------------------------------------------------------------
// fetch_perf_counter
// Free-running 32-bit stall counter for the fetch sequencer. Wraps at 2^32.
// Ports:
//   i_clk         : clock, posedge
//   i_resetN      : synchronous active-low reset, clears the count
//   i_stall       : count this cycle as a fetch stall
//   o_stallCycles : current count
// ---------------------------------------------------------------------------
module fetch_perf_counter (
  input  logic        i_clk,
  input  logic        i_resetN,
  input  logic        i_stall,
  output logic [31:0] o_stallCycles
);

  logic [31:0] r_count;

  // One increment per stalled cycle; natural unsigned wrap is intended.
  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_count <= '0;
    end else if (i_stall) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_stallCycles = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Control FSM for the single-issue core's fetch stage: sequences the PC
// (PCSrc/PCEn), runs a one-outstanding-request handshake with instruction
// memory and holds the fetched instruction for decode under backpressure.
// Redirects that land while a fetch is in flight mark the response as stale
// (kill) so it is dropped when it returns.
//
// Optional feature macro: FETCH_SEQ_PERF_EN adds the StallCycles port and the
// fetch_perf_counter instance. FSM behaviour does not depend on it.
//
// Ports:
//   CLK          : clock, posedge
//   ResetN       : synchronous active-low reset
//   ImemGnt      : memory accepts the request this cycle
//   ImemRvalid   : memory response valid
//   DecodeReady  : decode takes the held instruction
//   BranchTaken  : redirect to PCTarget
//   JumpReg      : redirect to ALUResult (jalr), outranks BranchTaken
//   Halt         : ecall/ebreak, stop fetching until reset
//   ImemReq      : fetch request at the current PC (Moore)
//   InstrLoad    : load instruction register from memory data (Mealy)
//   InstrValid   : instruction register valid for decode (Moore)
//   PCSrc        : PC mux select, 00 whenever PCEn is low (Mealy)
//   PCEn         : PC write enable (Mealy)
//   StallCycles  : stall counter (FETCH_SEQ_PERF_EN only)
// ---------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned RESET_STALL_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        ResetN,
  input  logic        ImemGnt,
  input  logic        ImemRvalid,
  input  logic        DecodeReady,
  input  logic        BranchTaken,
  input  logic        JumpReg,
  input  logic        Halt,
  output logic        ImemReq,
  output logic        InstrLoad,
  output logic        InstrValid,
  output logic [1:0]  PCSrc,
  output logic        PCEn
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0] StallCycles
`endif
);

  localparam logic [3:0] STALL_INIT = 4'(RESET_STALL_CYCLES);

  fetch_state_t r_state;
  fetch_state_t w_nextState;
  logic [3:0]   r_count;
  logic [3:0]   w_nextCount;
  logic         r_kill;
  logic         w_nextKill;
  logic         w_active;
  logic         w_redirect;

  // State register. Reset abandons any in-flight fetch: the kill flag is
  // cleared and IDLE ignores ImemRvalid, so a late response is harmless.
  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      r_state <= ST_IDLE;
      r_count <= STALL_INIT;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      r_kill  <= w_nextKill;
    end
  end

  // Redirects and Halt only matter while fetching; IDLE and HALTED ignore them.
  assign w_active   = (r_state == ST_REQ) || (r_state == ST_WAIT) || (r_state == ST_HOLD);
  assign w_redirect = BranchTaken | JumpReg;

  // Next state and outputs. The per-state case handles the normal flow, then
  // redirect drives the PC mux, and finally Halt overrides everything so the
  // PC is frozen on the cycle we stop.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextKill  = r_kill;
    ImemReq     = 1'b0;
    InstrValid  = 1'b0;
    InstrLoad   = 1'b0;
    PCEn        = 1'b0;
    PCSrc       = PCSRC_PLUS4;

    case (r_state)
      ST_IDLE: begin
        if (r_count == 4'd0) begin
          w_nextState = ST_REQ;
        end else begin
          w_nextCount = r_count - 4'd1;
        end
      end
      ST_REQ: begin
        ImemReq = 1'b1;
        if (ImemGnt) begin
          w_nextState = ST_WAIT;
          w_nextKill  = w_redirect;
        end
      end
      ST_WAIT: begin
        if (ImemRvalid) begin
          if (r_kill || w_redirect) begin
            w_nextState = ST_REQ;
            w_nextKill  = 1'b0;
          end else begin
            InstrLoad   = 1'b1;
            w_nextState = ST_HOLD;
          end
        end else if (w_redirect) begin
          w_nextKill = 1'b1;
        end
      end
      ST_HOLD: begin
        InstrValid = 1'b1;
        if (w_redirect) begin
          w_nextState = ST_REQ;
        end else if (DecodeReady) begin
          PCEn        = 1'b1;
          w_nextState = ST_REQ;
        end
      end
      ST_HALTED: begin
        w_nextState = ST_HALTED;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase

    if (w_active && w_redirect) begin
      PCEn  = 1'b1;
      PCSrc = redirectSrc(JumpReg);
    end

    if (w_active && Halt) begin
      w_nextState = ST_HALTED;
      PCEn        = 1'b0;
      PCSrc       = PCSRC_PLUS4;
      InstrLoad   = 1'b0;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic w_stall;

  // A stall is any cycle the fetch path waits on someone else.
  assign w_stall = ((r_state == ST_REQ)  && !ImemGnt)    ||
                   ((r_state == ST_WAIT) && !ImemRvalid) ||
                   ((r_state == ST_HOLD) && !DecodeReady);

  fetch_perf_counter u_perf (
    .i_clk         (CLK),
    .i_resetN      (ResetN),
    .i_stall       (w_stall),
    .o_stallCycles (StallCycles)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed walk through reset, straight-line fetch, redirects, backpressure,
// halt and reset-mid-fetch, followed by a randomized run. A transaction-level
// model of the fetch stage predicts the outputs every cycle, and a PC register
// driven by the DUT's PCEn/PCSrc tracks the addresses being fetched.
// Define FETCH_SEQ_PERF_EN to cover the stall counter as well.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int STALL = 2;

  logic        CLK = 1'b0;
  logic        ResetN;
  logic        ImemGnt;
  logic        ImemRvalid;
  logic        DecodeReady;
  logic        BranchTaken;
  logic        JumpReg;
  logic        Halt;
  logic        ImemReq;
  logic        InstrLoad;
  logic        InstrValid;
  logic [1:0]  PCSrc;
  logic        PCEn;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] StallCycles;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model of the fetch stage: which phase the fetch is in, plus bookkeeping.
  bit          mIdle, mReq, mWait, mHold, mHalted, mKill;
  int          mCountdown, mAge;
  logic [31:0] mStalls;

  // Environment: the PC register and its mux inputs.
  logic [31:0] pcReg, pcTarget, aluResult;
  logic [31:0] grantAddrs[$];
  bit          recordGrants;

  // DUT outputs as sampled mid-cycle.
  logic        seenReq, seenLoad, seenValid, seenEn;
  logic [1:0]  seenSrc;
  logic [31:0] seenStall;

  always #5 CLK = ~CLK;

  fetch_sequencer #(.RESET_STALL_CYCLES(STALL)) dut (
    .CLK         (CLK),
    .ResetN      (ResetN),
    .ImemGnt     (ImemGnt),
    .ImemRvalid  (ImemRvalid),
    .DecodeReady (DecodeReady),
    .BranchTaken (BranchTaken),
    .JumpReg     (JumpReg),
    .Halt        (Halt),
    .ImemReq     (ImemReq),
    .InstrLoad   (InstrLoad),
    .InstrValid  (InstrValid),
    .PCSrc       (PCSrc),
    .PCEn        (PCEn)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .StallCycles (StallCycles)
`endif
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d observed %0h expected %0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic resetModel();
    mIdle = 1; mReq = 0; mWait = 0; mHold = 0; mHalted = 0; mKill = 0;
    mCountdown = STALL; mAge = 0; mStalls = '0; pcReg = '0;
  endtask

  // Predict this cycle's outputs from the fetch phase and current inputs.
  task automatic checkOutput();
    bit live, redir, haltNow;
    logic expEn, expLoad;
    logic [1:0] expSrc;
    live    = mReq || mWait || mHold;
    redir   = live && (BranchTaken || JumpReg);
    haltNow = live && Halt;
    expEn   = 1'b0;
    expSrc  = 2'b00;
    if (!haltNow) begin
      if (redir) begin
        expEn  = 1'b1;
        expSrc = JumpReg ? 2'b10 : 2'b01;
      end else if (mHold && DecodeReady) begin
        expEn = 1'b1;
      end
    end
    expLoad = mWait && ImemRvalid && !mKill && !redir && !haltNow;

    seenReq = ImemReq; seenLoad = InstrLoad; seenValid = InstrValid;
    seenEn = PCEn; seenSrc = PCSrc;
    cmp("ImemReq", 32'(ImemReq), 32'(mReq));
    cmp("InstrValid", 32'(InstrValid), 32'(mHold));
    cmp("InstrLoad", 32'(InstrLoad), 32'(expLoad));
    cmp("PCEn", 32'(PCEn), 32'(expEn));
    cmp("PCSrc", 32'(PCSrc), 32'(expSrc));
`ifdef FETCH_SEQ_PERF_EN
    seenStall = StallCycles;
    cmp("StallCycles", StallCycles, mStalls);
`else
    seenStall = '0;
`endif
    if (recordGrants && ImemReq && ImemGnt) grantAddrs.push_back(pcReg);
  endtask

  // Advance the model across the clock edge with the inputs just applied.
  task automatic advanceModel();
    bit live, redir, haltNow;
    if (!ResetN) begin
      resetModel();
      return;
    end
    live    = mReq || mWait || mHold;
    redir   = live && (BranchTaken || JumpReg);
    haltNow = live && Halt;
    if ((mReq && !ImemGnt) || (mWait && !ImemRvalid) || (mHold && !DecodeReady))
      mStalls = mStalls + 32'd1;
    if (seenEn) begin
      case (seenSrc)
        2'b00:   pcReg = pcReg + 32'd4;
        2'b01:   pcReg = pcTarget;
        2'b10:   pcReg = aluResult;
        default: pcReg = 32'hxxxx_xxxx;
      endcase
    end
    if (haltNow) begin
      mReq = 0; mWait = 0; mHold = 0; mHalted = 1;
    end else if (mIdle) begin
      if (mCountdown == 0) begin mIdle = 0; mReq = 1; end
      else mCountdown--;
    end else if (mReq) begin
      if (ImemGnt) begin mReq = 0; mWait = 1; mKill = redir; mAge = 1; end
    end else if (mWait) begin
      if (ImemRvalid) begin
        mWait = 0;
        if (mKill || redir) begin mReq = 1; mKill = 0; end
        else mHold = 1;
      end else begin
        if (redir) mKill = 1;
        mAge++;
      end
    end else if (mHold) begin
      if (redir || DecodeReady) begin mHold = 0; mReq = 1; end
    end
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, step model at posedge.
  // The memory answers once the request has waited 'lat' cycles in flight.
  task automatic applyStimulus(input bit rstN, input bit gnt, input bit ready,
                               input bit br, input bit jr, input bit hlt,
                               input int lat, input bit lateRvalid);
    @(negedge CLK);
    ResetN      = rstN;
    ImemGnt     = gnt;
    DecodeReady = ready;
    BranchTaken = br;
    JumpReg     = jr;
    Halt        = hlt;
    ImemRvalid  = (mWait && mAge >= lat) || lateRvalid;
    #1;
    checkOutput();
    @(posedge CLK);
    advanceModel();
    cycle++;
  endtask

  initial begin
    bit rstN, hlt, late;
    logic [31:0] stallBefore;

    ResetN = 0; ImemGnt = 0; ImemRvalid = 0; DecodeReady = 0;
    BranchTaken = 0; JumpReg = 0; Halt = 0;
    pcTarget = '0; aluResult = '0; recordGrants = 0;
    @(posedge CLK);
    resetModel();

    // Second reset cycle: everything quiet.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    cmp("resetReq", 32'(seenReq), 0);
    cmp("resetEn", 32'(seenEn), 0);

    // Release: three IDLE cycles, then the first request.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 0, 0, 0, 1, 0);
      cmp("idleNoReq", 32'(seenReq), 0);
    end

    // Straight-line fetch from PC 0, PCEn every third cycle.
    recordGrants = 1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 1, 1, 0, 0, 0, 1, 0);
      if (i == 0) cmp("reqRise", 32'(seenReq), 1);
      cmp("plus4Cadence", 32'(seenEn), (i % 3 == 2) ? 32'd1 : 32'd0);
    end
    cmp("grantCount", grantAddrs.size(), 3);
    if (grantAddrs.size() == 3) begin
      cmp("pc0", grantAddrs[0], 32'h0);
      cmp("pc4", grantAddrs[1], 32'h4);
      cmp("pc8", grantAddrs[2], 32'h8);
    end

    // Branch while the PC 8 response is still outstanding.
    pcTarget = 32'h100;
    applyStimulus(1, 1, 1, 1, 0, 0, 2, 0);
    cmp("waitRedirEn", 32'(seenEn), 1);
    cmp("waitRedirSrc", 32'(seenSrc), 32'h1);
    applyStimulus(1, 1, 1, 0, 0, 0, 1, 0);
    cmp("staleDropped", 32'(seenLoad), 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 1, 0);
    cmp("reqAfterBranch", 32'(seenReq), 1);
    cmp("pcTarget", grantAddrs[$], 32'h100);
    applyStimulus(1, 1, 1, 0, 0, 0, 1, 0);
    cmp("loadTarget", 32'(seenLoad), 1);

    // JumpReg and BranchTaken together in HOLD.
    aluResult = 32'h010;
    pcTarget  = 32'h200;
    applyStimulus(1, 1, 1, 1, 1, 0, 1, 0);
    cmp("holdValid", 32'(seenValid), 1);
    cmp("jalrSrc", 32'(seenSrc), 32'h2);
    applyStimulus(1, 1, 1, 0, 0, 0, 1, 0);
    cmp("validDropped", 32'(seenValid), 0);
    cmp("pcAlu", grantAddrs[$], 32'h010);
    applyStimulus(1, 1, 1, 0, 0, 0, 1, 0);

    // Five cycles of backpressure, then halt.
    stallBefore = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 0);
      if (i == 0) stallBefore = seenStall;
      cmp("validSteady", 32'(seenValid), 1);
      cmp("noAdvance", 32'(seenEn), 0);
    end
    applyStimulus(1, 1, 1, 0, 0, 1, 1, 0);
    cmp("haltNoEn", 32'(seenEn), 0);
`ifdef FETCH_SEQ_PERF_EN
    cmp("stallDelta", seenStall - stallBefore, 32'd5);
`endif
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 1, i[0], i[1], 0, 1, 1);
      cmp("haltedNoReq", 32'(seenReq), 0);
      cmp("haltedNoValid", 32'(seenValid), 0);
      cmp("haltedNoLoad", 32'(seenLoad), 0);
    end

    // Reset in the middle of a fetch, then a late response.
    recordGrants = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 9, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 9, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 9, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 9, 1);
    cmp("lateRvalidNoLoad", 32'(seenLoad), 0);
    cmp("lateRvalidIdle", 32'(seenReq), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rstN = ($urandom_range(99) >= 3);
      hlt  = !mIdle && ($urandom_range(99) == 0);
      late = (mIdle || mHalted || mReq) && ($urandom_range(9) == 0);
      pcTarget  = $urandom & 32'hFFFF_FFFC;
      aluResult = $urandom & 32'hFFFF_FFFC;
      applyStimulus(rstN, 1'($urandom_range(1)), 1'($urandom_range(1)),
                    $urandom_range(99) < 15, $urandom_range(99) < 10, hlt,
                    $urandom_range(3, 1), late);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
